irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 15 +
 rtl/irq_ctrl_prio_enc.sv | 25 ++
 rtl/irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_irq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// FSM state encoding plus default vector base/stride.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [15:0] VEC_BASE_DEF   = 16'h0F80;
    localparam logic [15:0] VEC_STRIDE_DEF = 16'h0020;
    localparam int          IDX_W          = 4;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: highest set request index wins.
// any flags a non-empty request vector.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // Scan upwards so the last (highest) hit overrides lower ones.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i]) begin
                any = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched sources, mask, priority take FSM.
// Define IRQ_SYNC_EN to insert a 2-flop synchronizer on src_in.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                 NUM_SRC    = 4,
    parameter int                 ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
    parameter logic [ADDR_W-1:0]  VEC_STRIDE = ADDR_W'(VEC_STRIDE_DEF),
    parameter logic [NUM_SRC-1:0] MASK_RST   = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               accept_en,
    input  logic               ret,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    output logic               irq_take,
    output logic [ADDR_W-1:0]  irq_vec,
    output logic [IDX_W-1:0]   irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    irq_state_e         r_state;
    logic               r_take;
    logic [ADDR_W-1:0]  r_vec;
    logic [IDX_W-1:0]   r_id;
    logic               r_insvc;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_prev;

    logic [NUM_SRC-1:0] w_src;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_any;
    logic [IDX_W-1:0]   w_idx;
    logic               w_take;
    logic [ADDR_W-1:0]  w_slot;
    logic [ADDR_W-1:0]  w_vec;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    // Two-stage synchronizer for asynchronous request lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = src_in;
`endif

    assign w_edge = w_src & ~r_prev;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_enc (
        .req (r_pending & r_mask),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_take = (r_state == ST_IDLE) && w_any && accept_en;
    assign w_clr  = w_take ? (NUM_SRC'(1) << w_idx) : '0;
    assign w_slot = ADDR_W'(NUM_SRC - 1) - ADDR_W'(w_idx);
    assign w_vec  = VEC_BASE + w_slot * VEC_STRIDE;

    // Edge sampling and pending latch; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= w_src;
            r_pending <= (r_pending & ~w_clr) | w_edge;
        end
    end

    // Mask register; the take decision this cycle still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= MASK_RST;
        end else if (mask_wr) begin
            r_mask <= mask_data;
        end
    end

    // Take FSM with registered redirect outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_take  <= 1'b0;
            r_vec   <= '0;
            r_id    <= '0;
            r_insvc <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state <= ST_TAKE;
                        r_take  <= 1'b1;
                        r_vec   <= w_vec;
                        r_id    <= w_idx;
                        r_insvc <= 1'b1;
                    end
                end
                ST_TAKE: begin
                    r_state <= ST_SERVICE;
                    r_take  <= 1'b0;
                end
                ST_SERVICE: begin
                    if (ret) begin
                        r_state <= ST_IDLE;
                        r_insvc <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_take  <= 1'b0;
                    r_insvc <= 1'b0;
                end
            endcase
        end
    end

    assign irq_take   = r_take;
    assign irq_vec    = r_vec;
    assign irq_id     = r_id;
    assign in_service = r_insvc;
    assign pending    = r_pending;
    assign mask       = r_mask;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus random traffic.
// A transaction-level model predicts each take; a monitor checks them.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  src_in;
    logic        accept_en;
    logic        ret;
    logic        mask_wr;
    logic [3:0]  mask_data;
    logic        irq_take;
    logic [15:0] irq_vec;
    logic [3:0]  irq_id;
    logic        in_service;
    logic [3:0]  pending;
    logic [3:0]  mask;

    irq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_in     (src_in),
        .accept_en  (accept_en),
        .ret        (ret),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .irq_take   (irq_take),
        .irq_vec    (irq_vec),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] vec;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    int   n_chk;
    int   n_err;
    int   cyc;
    int   ntakes;
    int   last_id;
    int   last_vec;
    int   last_cyc;

    logic [3:0] m_prev;
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    logic [3:0] m_s1;
    logic [3:0] m_s2;
    bit         m_busy;
    bit         m_fresh;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] vec_of(input int id);
        return 16'(32'h0F80 + (3 - id) * 32'h20);
    endfunction

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_mask  = 4'hF;
        m_s1    = '0;
        m_s2    = '0;
        m_busy  = 0;
        m_fresh = 0;
        expq.delete();
    endtask

    // Reference model: one step per rising edge, from the pre-edge inputs.
    always @(posedge clk) begin
        logic [3:0] s;
        logic [3:0] edges;
        logic [3:0] elig;
        int         win;
        if (rst_n) begin
            cyc++;
`ifdef IRQ_SYNC_EN
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = src_in;
`else
            s = src_in;
`endif
            edges  = s & ~m_prev;
            m_prev = s;
            elig   = m_pend & m_mask;
            win    = -1;
            if (!m_busy && accept_en) begin
                for (int i = 3; i >= 0; i--) begin
                    if (elig[i]) begin
                        win = i;
                        break;
                    end
                end
            end
            if (m_busy) begin
                if (!m_fresh && ret) m_busy = 0;
                m_fresh = 0;
            end
            if (win >= 0) begin
                m_busy      = 1;
                m_fresh     = 1;
                m_pend[win] = 1'b0;
                expq.push_back('{win, vec_of(win), cyc});
            end
            m_pend = m_pend | edges;
            if (mask_wr) m_mask = mask_data;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a take.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("in_service", 32'(in_service), 32'(m_busy));
            check("pending", 32'(pending), 32'(m_pend));
            check("mask", 32'(mask), 32'(m_mask));
            if (irq_take) begin
                if (expq.size() == 0) begin
                    check("unexpected_take", 32'(irq_take), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("irq_id", 32'(irq_id), 32'(e.id));
                    check("irq_vec", 32'(irq_vec), 32'(e.vec));
                    check("take_cyc", 32'(cyc), 32'(e.cyc));
                end
                ntakes++;
                last_id  = int'(irq_id);
                last_vec = int'(irq_vec);
                last_cyc = cyc;
            end else if (expq.size() != 0) begin
                e = expq.pop_front();
                check("missed_take", 32'(irq_take), 32'd1);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_take(input int n0);
        int k;
        k = 0;
        while (ntakes == n0 && k < 30) begin
            nxt();
            k++;
        end
        check("take_seen", 32'(ntakes > n0), 32'd1);
    endtask

    task automatic do_ret();
        nxt();
        ret = 1'b1;
        nxt();
        ret = 1'b0;
    endtask

    task automatic check_reset_outs();
        check("rst_take", 32'(irq_take), 32'd0);
        check("rst_vec", 32'(irq_vec), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_insvc", 32'(in_service), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_mask", 32'(mask), 32'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n0;
        n_chk = 0; n_err = 0; cyc = 0; ntakes = 0;
        last_id = -1; last_vec = 0; last_cyc = 0;
        rst_n = 1'b0; src_in = '0; accept_en = 1'b1; ret = 1'b0;
        mask_wr = 1'b0; mask_data = '0;
        model_reset();
        nxt(); nxt();
        check_reset_outs();
        rst_n = 1'b1;
        nxt();

        // Single source 0 pulse.
        n0 = ntakes; c = cyc;
        src_in = 4'b0001; nxt(); src_in = '0;
        wait_take(n0);
        check("s1_id", 32'(last_id), 32'd0);
        check("s1_vec", 32'(last_vec), 32'h0FE0);
        check("s1_lat", 32'(last_cyc), 32'(c + 2 + SYNC));
        check("s1_pend", 32'(pending), 32'd0);
        do_ret();

        // Sources 3 and 1 together; ret during TAKE is ignored.
        nxt();
        n0 = ntakes;
        src_in = 4'b1010; nxt(); src_in = '0;
        wait_take(n0);
        check("s2a_id", 32'(last_id), 32'd3);
        check("s2a_vec", 32'(last_vec), 32'h0F80);
        ret = 1'b1; nxt(); ret = 1'b0;
        check("s2_ret_in_take", 32'(in_service), 32'd1);
        n0 = ntakes; c = cyc;
        ret = 1'b1; nxt(); ret = 1'b0;
        wait_take(n0);
        check("s2b_id", 32'(last_id), 32'd1);
        check("s2b_vec", 32'(last_vec), 32'h0FC0);
        check("s2b_cyc", 32'(last_cyc), 32'(c + 2));
        do_ret();

        // Masked source stays latched until unmasked.
        nxt();
        mask_wr = 1'b1; mask_data = 4'b1110; nxt(); mask_wr = 1'b0;
        n0 = ntakes;
        src_in = 4'b0001; nxt(); src_in = '0;
        repeat (4 + SYNC) nxt();
        check("s3_notake", 32'(ntakes), 32'(n0));
        check("s3_pend", 32'(pending), 32'b0001);
        c = cyc;
        mask_wr = 1'b1; mask_data = 4'hF; nxt(); mask_wr = 1'b0;
        wait_take(n0);
        check("s3_id", 32'(last_id), 32'd0);
        check("s3_cyc", 32'(last_cyc), 32'(c + 2));
        do_ret();

        // Edge during service waits for ret and accept_en.
        nxt();
        n0 = ntakes;
        src_in = 4'b1000; nxt(); src_in = '0;
        wait_take(n0);
        nxt();
        n0 = ntakes;
        src_in = 4'b0100; nxt(); src_in = '0;
        repeat (4 + SYNC) nxt();
        check("s4_nonest", 32'(ntakes), 32'(n0));
        check("s4_pend", 32'(pending), 32'b0100);
        accept_en = 1'b0;
        ret = 1'b1; nxt(); ret = 1'b0;
        repeat (5) nxt();
        check("s4_stall", 32'(ntakes), 32'(n0));
        check("s4_hold", 32'(pending), 32'b0100);
        c = cyc;
        accept_en = 1'b1;
        wait_take(n0);
        check("s4_id", 32'(last_id), 32'd2);
        check("s4_cyc", 32'(last_cyc), 32'(c + 1));
        do_ret();

        // Reset during service abandons it.
        nxt();
        n0 = ntakes;
        src_in = 4'b0010; nxt(); src_in = '0;
        wait_take(n0);
        nxt();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outs();
        nxt();
        rst_n = 1'b1;
        n0 = ntakes;
        ret = 1'b1; nxt(); ret = 1'b0;
        nxt();
        check("s5_idle", 32'(in_service), 32'd0);
        check("s5_notake", 32'(ntakes), 32'(n0));
        src_in = 4'b0100; nxt(); src_in = '0;
        wait_take(n0);
        check("s5_id", 32'(last_id), 32'd2);
        do_ret();

        // Source held high through reset release counts as an edge.
        nxt();
        src_in = 4'b0001;
        rst_n = 1'b0;
        model_reset();
        nxt();
        n0 = ntakes; c = cyc;
        rst_n = 1'b1;
        wait_take(n0);
        check("s6_id", 32'(last_id), 32'd0);
        check("s6_cyc", 32'(last_cyc), 32'(c + 2 + SYNC));
        src_in = '0;
        do_ret();

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            src_in    = src_in ^ 4'($urandom & $urandom);
            accept_en = ($urandom % 5) != 0;
            ret       = ($urandom % 3) == 0;
            mask_wr   = ($urandom % 16) == 0;
            mask_data = 4'($urandom);
            nxt();
        end
        src_in = '0; accept_en = 1'b1; mask_wr = 1'b0;
        ret = 1'b1;
        repeat (40) nxt();
        ret = 1'b0;
        nxt();
        check("drain", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
